// File: rtl/conv_pkg.sv
// Shared constants and types for the rate-1/2, K=3 convolutional encoder.
package conv_pkg;

   localparam int unsigned CONV_K  = 3;
   localparam logic [2:0]  CONV_G0 = 3'b111;
   localparam logic [2:0]  CONV_G1 = 3'b101;

   typedef logic [1:0] conv_sym_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DATA = 2'd1,
      TAIL = 2'd2
   } conv_enc_state_e;

endpackage

// File: rtl/conv_enc_out_reg.sv
// Valid/ready output register for code symbols; exports the combinational load strobe.
module conv_enc_out_reg
   import conv_pkg::*;
(
   input  logic      clk_i,
   input  logic      rst_ni,
   input  logic      push_i,
   input  conv_sym_t symbol_i,
   input  logic      last_i,
   input  logic      ready_i,
   output logic      load_c_o,
   output logic      valid_o,
   output conv_sym_t symbol_o,
   output logic      last_o
);

   logic      valid_q, valid_d;
   conv_sym_t sym_q, sym_d;
   logic      last_q, last_d;

   assign load_c_o = !valid_q || ready_i;

   // Symbol and last hold while stalled; an empty load only drops valid.
   always_comb begin
      valid_d = valid_q;
      sym_d   = sym_q;
      last_d  = last_q;
      if (load_c_o) begin
         valid_d = push_i;
         if (push_i) begin
            sym_d  = symbol_i;
            last_d = last_i;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_q <= 1'b0;
         sym_q   <= 2'b00;
         last_q  <= 1'b0;
      end else begin
         valid_q <= valid_d;
         sym_q   <= sym_d;
         last_q  <= last_d;
      end
   end

   assign valid_o  = valid_q;
   assign symbol_o = sym_q;
   assign last_o   = last_q;

endmodule

// File: rtl/conv_encoder.sv
// Feed-forward convolutional encoder with zero-tail frame termination.
// Optional symbol error injection via `CONV_ENC_ERR_INJ_EN.
module conv_encoder
   import conv_pkg::*;
#(
   parameter int unsigned    K  = CONV_K,
   parameter logic [K-1:0]   G0 = K'(CONV_G0),
   parameter logic [K-1:0]   G1 = K'(CONV_G1)
) (
   input  logic      i_clk,
   input  logic      i_rst_n,
   input  logic      i_valid,
   output logic      o_ready,
   input  logic      i_data,
   input  logic      i_last,
   output logic      o_valid,
   input  logic      i_ready,
   output conv_sym_t o_symbol,
   output logic      o_last,
   output logic      o_busy
`ifdef CONV_ENC_ERR_INJ_EN
   ,
   input  logic [1:0] i_err_mask
`endif
);

   localparam int unsigned SW  = K - 1;
   localparam int unsigned TCW = $clog2(K);

   conv_enc_state_e state_q;
   logic [SW-1:0]   sr_q;
   logic [TCW-1:0]  tcnt_q;
   logic            busy_q;

   logic            load_c;
   logic            accept_c;
   logic            tail_load_c;
   logic            push_c;
   logic            in_bit_c;
   logic            last_sym_c;
   logic [K-1:0]    win_c;
   conv_sym_t       sym_c;

   // Tail loads feed zeros so the trellis ends in state 0.
   always_comb begin
      o_ready     = load_c && (state_q != TAIL);
      accept_c    = i_valid && o_ready;
      tail_load_c = load_c && (state_q == TAIL);
      push_c      = accept_c || tail_load_c;
      in_bit_c    = (state_q == TAIL) ? 1'b0 : i_data;
      win_c       = {in_bit_c, sr_q};
      sym_c       = {^(win_c & G0), ^(win_c & G1)};
`ifdef CONV_ENC_ERR_INJ_EN
      sym_c       = sym_c ^ i_err_mask;
`endif
      last_sym_c  = tail_load_c && (tcnt_q == TCW'(K - 2));
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= IDLE;
         sr_q    <= '0;
         tcnt_q  <= '0;
         busy_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE, DATA: begin
               if (accept_c) begin
                  sr_q   <= win_c[K-1:1];
                  busy_q <= 1'b1;
                  if (i_last) begin
                     state_q <= TAIL;
                     tcnt_q  <= '0;
                  end else begin
                     state_q <= DATA;
                  end
               end
            end
            TAIL: begin
               if (tail_load_c) begin
                  sr_q <= win_c[K-1:1];
                  if (tcnt_q != TCW'(K - 1)) begin
                     tcnt_q <= tcnt_q + TCW'(1);
                  end
                  if (tcnt_q == TCW'(K - 2)) begin
                     state_q <= IDLE;
                     busy_q  <= 1'b0;
                  end
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign o_busy = busy_q;

   conv_enc_out_reg u_out_reg (
      .clk_i    (i_clk),
      .rst_ni   (i_rst_n),
      .push_i   (push_c),
      .symbol_i (sym_c),
      .last_i   (last_sym_c),
      .ready_i  (i_ready),
      .load_c_o (load_c),
      .valid_o  (o_valid),
      .symbol_o (o_symbol),
      .last_o   (o_last)
   );

endmodule

// File: doc/conv_encoder.md
# conv_encoder

Rate-1/2, constraint-length-3 feed-forward convolutional encoder with zero-tail frame termination; it sits directly upstream of `viterbi_deocode` and produces the 2-bit code symbols that drive its `i_input_data`. It accepts one information bit per valid/ready handshake and emits one registered 2-bit symbol per handshake. At the end of each frame it appends K-1 flush symbols, so the decoder trellis always terminates in state 0.

## Interface
- `K`, default 3: constraint length. The shift state is K-1 bits wide.
- `G0`, default 3'b111: generator for `o_symbol[1]`. Bit K-1 taps the current input; bit 0 taps the oldest state bit.
- `G1`, default 3'b101: generator for `o_symbol[0]`, with the same bit ordering as `G0`.
- `i_clk`  in  1  single clock; all logic is on its rising edge.
- `i_rst_n`  in  1  asynchronous, active-low reset.
- `i_valid`  in  1  upstream information bit valid.
- `o_ready`  out  1  encoder can accept a bit this cycle.
- `i_data`  in  1  information bit.
- `i_last`  in  1  qualifies `i_data` as the final bit of the frame.
- `o_valid`  out  1  `o_symbol` valid.
- `i_ready`  in  1  downstream accepts the symbol.
- `o_symbol`  out  2  code symbol, ordered {G0 output, G1 output}.
- `o_last`  out  1  marks the final tail symbol of the frame.
- `o_busy`  out  1  high in DATA or TAIL.
- `i_err_mask`  in  2  present only when `CONV_ENC_ERR_INJ_EN` is defined; see Configuration.

## Operation
- Shift state `sr[K-2:0]`, where `sr[K-2]` is the most recent bit. Each symbol bit is the XOR-reduction of `{in, sr} & G`.
- FSM states:
  - IDLE to DATA on an accepted bit with `i_last` = 0.
  - IDLE or DATA to TAIL on an accepted bit with `i_last` = 1.
  - TAIL injects in = 0 each time the output register loads. After K-1 tail loads it returns to IDLE. The final tail load sets `o_last`.
- The shift state is all-zero on entry to IDLE. A frame may start from IDLE with a single bit that has `i_last` = 1.
- Output register load condition: `load = !o_valid || i_ready`.
- `o_ready = load && (state != TAIL)`.
- Bit accept condition: `i_valid && o_ready`.
- In TAIL, a flush symbol loads whenever `load` is true, regardless of `i_valid`.
- With `o_valid` = 1 and `i_ready` = 0:
  - `o_symbol` and `o_last` hold stable.
  - The shift state and FSM do not advance.
- `o_valid` clears when the register is consumed and nothing new loads.
- Frame length is unbounded; there is no internal bit counter. The tail counter is `$clog2(K)` bits wide and saturates at K-1.
- Simultaneous events:
  - A consume and a new load in the same cycle is a load; there is no bubble.
  - The last tail symbol being consumed and the first bit of the next frame being accepted may happen in the same cycle.
- Reset values: `o_valid` = 0, `o_symbol` = 2'b00, `o_last` = 0, `o_busy` = 0, FSM in IDLE, `sr` = 0.
  - `o_ready` is combinational and is therefore 1 out of reset.
  - Reset mid-frame discards the partial frame; the next frame starts from state 0.

## Timing
- One cycle from an accepted bit to the corresponding `o_valid`/`o_symbol`.
- Throughput is one symbol per cycle while `i_ready` = 1.
- Frame of N bits produces N + K - 1 symbols.
- Tail cycles stall `o_ready` for K-1 loads.
- `o_ready` depends combinationally on `i_ready`. `o_valid`, `o_symbol` and `o_last` are registered.

## Configuration
- `CONV_ENC_ERR_INJ_EN` defined:
  - Port `i_err_mask[1:0]` exists.
  - It is sampled on every load, including tail loads, and XORed into the registered symbol.
  - Encoder state is unaffected. This is used to exercise decoder error correction.
- `CONV_ENC_ERR_INJ_EN` undefined: the port is absent and symbols are the pure code output.

## Structure
- Package `conv_pkg` holds:
  - `CONV_K`, `CONV_G0` and `CONV_G1` constants, which are the parameter defaults.
  - Typedef `conv_sym_t` (logic [1:0]).
  - Enum `conv_enc_state_e` {IDLE, DATA, TAIL}.
- Sub-module `conv_enc_out_reg`: the valid/ready output register carrying symbol and last, exporting `load`.
- The FSM, shift state and generator XORs stay in `conv_encoder`.

## Test plan
- Frame 1,0,1,1 (last on 4th bit), `i_ready` held 1 -> symbols 11,10,00,01,01,11 on consecutive cycles; `o_last` on the 6th only; `o_busy` low afterwards.
- Single-bit frame 1 with `i_last` -> 11,10,11, `o_last` on the 3rd symbol; `o_ready` low for the 2 tail loads.
- Frame 1,0,1,1 with `i_ready` toggling 1,0,0,1,... -> identical symbol sequence; `o_symbol` stable during every stall; no symbol lost or duplicated.
- Back-to-back frames 1,1(last) then 1(last) with `i_valid` continuous -> 11,01,01,11 then 11,10,11; the second frame starts from state 0.
- Reset asserted after the 2nd bit of a 4-bit frame -> outputs return to reset values immediately; the next frame with the single bit 1 yields 11,10,11.
- With `CONV_ENC_ERR_INJ_EN`, frame 1,0,1,1 and `i_err_mask` = 2'b10 on the 2nd load only -> 11,00,00,01,01,11.
